// File: rtl/riscv_pipe_stage_reg.sv
// Generic RISC-V pipeline stage register: NCH x DWIDTH channels with valid/ready and sync flush.
// Define RISCV_PIPE_SKID_EN for a registered o_ready backed by a one-entry skid buffer.
`ifndef XLEN
`define XLEN 32
`endif

module riscv_pipe_stage_reg #(
    parameter int unsigned       DWIDTH        = `XLEN,
    parameter int unsigned       NCH           = 3,
    parameter logic [DWIDTH-1:0] REGISTER_INIT = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_clr,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [NCH*DWIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [NCH*DWIDTH-1:0] o_data
);

    localparam int unsigned       BW       = NCH * DWIDTH;
    localparam logic [BW-1:0]     INIT_BUS = {NCH{REGISTER_INIT}};

    logic up;
    logic down;

    assign up   = i_valid & o_ready;
    assign down = o_valid & i_ready;

`ifdef RISCV_PIPE_SKID_EN

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state;
    logic [BW-1:0] skid;

    // o_ready is a flop: it drops only once the skid entry is occupied.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state   <= EMPTY;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            o_data  <= INIT_BUS;
            skid    <= INIT_BUS;
        end else if (i_clr) begin
            state   <= EMPTY;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            o_data  <= INIT_BUS;
            skid    <= INIT_BUS;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (up) begin
                        o_data  <= i_data;
                        o_valid <= 1'b1;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (up && down) begin
                        o_data <= i_data;
                    end else if (up) begin
                        skid    <= i_data;
                        o_ready <= 1'b0;
                        state   <= FULL;
                    end else if (down) begin
                        o_valid <= 1'b0;
                        state   <= EMPTY;
                    end
                end
                FULL: begin
                    if (down) begin
                        o_data  <= skid;
                        skid    <= INIT_BUS;
                        o_ready <= 1'b1;
                        state   <= BUSY;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                end
            endcase
        end
    end

`else

    // Ready passes straight through from downstream for full throughput.
    assign o_ready = ~o_valid | i_ready;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_valid <= 1'b0;
            o_data  <= INIT_BUS;
        end else if (i_clr) begin
            o_valid <= 1'b0;
            o_data  <= INIT_BUS;
        end else if (up) begin
            o_valid <= 1'b1;
            o_data  <= i_data;
        end else if (down) begin
            o_valid <= 1'b0;
        end
    end

`endif

endmodule

// File: tb/tb_riscv_pipe_stage_reg.sv
// Scoreboard bench for riscv_pipe_stage_reg (NCH=3, DWIDTH=32, REGISTER_INIT=0), either skid setting.
module tb_riscv_pipe_stage_reg;

    localparam int unsigned DW = 32;
    localparam int unsigned NC = 3;
    localparam int unsigned BW = DW * NC;
`ifdef RISCV_PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic          clk;
    logic          rstn;
    logic          i_clr;
    logic          i_valid;
    logic          o_ready;
    logic [BW-1:0] i_data;
    logic          o_valid;
    logic          i_ready;
    logic [BW-1:0] o_data;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: words held by the stage (head is on o_data) and the last word shown.
    logic [BW-1:0] q[$];
    logic [BW-1:0] last_data;

    riscv_pipe_stage_reg #(
        .DWIDTH(DW),
        .NCH(NC),
        .REGISTER_INIT('0)
    ) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .i_clr  (i_clr),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_data (i_data),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_data (o_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] pack(input logic [DW-1:0] a);
        return {a + DW'(2), a + DW'(1), a};
    endfunction

    function automatic logic model_ready();
        if (SKID) return q.size() < 2;
        return (q.size() == 0) || i_ready;
    endfunction

    // Model update at each active edge: pop on downstream transfer, push on upstream transfer.
    always @(posedge clk) begin
        logic m_up;
        logic m_down;
        if (!rstn) begin
            q.delete();
            last_data = '0;
        end else begin
            m_down = (q.size() != 0) && i_ready;
            m_up   = i_valid && model_ready();
            if (i_clr) begin
                q.delete();
                last_data = '0;
            end else begin
                if (m_down) begin
                    last_data = q[0];
                    void'(q.pop_front());
                end
                if (m_up) q.push_back(i_data);
            end
        end
    end

    // Monitor: compare handshake and presented data against the model away from the edge.
    always @(negedge clk) begin
        logic          e_valid;
        logic [BW-1:0] e_data;
        e_valid = q.size() != 0;
        e_data  = e_valid ? q[0] : last_data;
        chk("mon_valid", BW'(o_valid), BW'(e_valid));
        chk("mon_ready", BW'(o_ready), BW'(model_ready()));
        if (o_valid && i_ready) chk("mon_deliver", o_data, e_data);
        else chk("mon_hold", o_data, e_data);
    end

    task automatic set(input logic v, input logic [BW-1:0] d, input logic r, input logic c);
        i_valid = v;
        i_data  = d;
        i_ready = r;
        i_clr   = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0;
        set(1'b0, '0, 1'b0, 1'b0);
        tick();
        chk("rst_valid", BW'(o_valid), BW'(1'b0));
        chk("rst_data", o_data, '0);
        chk("rst_ready", BW'(o_ready), BW'(1'b1));
        tick();
        rstn = 1'b1;
        tick();

        // Streaming: triples appear one cycle after acceptance.
        for (int i = 1; i <= 3; i++) begin
            set(1'b1, pack(DW'(i * 16)), 1'b1, 1'b0);
            tick();
            chk("stream_data", o_data, pack(DW'(i * 16)));
            chk("stream_valid", BW'(o_valid), BW'(1'b1));
            chk("stream_ready", BW'(o_ready), BW'(1'b1));
        end
        set(1'b0, '0, 1'b1, 1'b0);
        tick();
        chk("stream_end_valid", BW'(o_valid), BW'(1'b0));
        chk("stream_stale", o_data, pack(32'h30));

        // Back-pressure with upstream still offering a second word.
        set(1'b1, 96'h00000033_00000022_00000011, 1'b1, 1'b0);
        tick();
        set(1'b1, 96'h00000066_00000055_00000044, 1'b0, 1'b0);
        #1;
        chk("bp_ready_first", BW'(o_ready), SKID ? BW'(1'b1) : BW'(1'b0));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_hold_data", o_data, 96'h00000033_00000022_00000011);
            chk("bp_hold_ready", BW'(o_ready), BW'(1'b0));
        end
        set(1'b1, 96'h00000066_00000055_00000044, 1'b1, 1'b0);
        tick();
        chk("bp_release_data", o_data, 96'h00000066_00000055_00000044);
        chk("bp_release_valid", BW'(o_valid), BW'(1'b1));
        set(1'b0, '0, 1'b1, 1'b0);
        tick();
        chk("bp_drain_valid", BW'(o_valid), BW'(1'b0));

        // Flush discards both the held word and the one offered alongside i_clr.
        set(1'b1, {3{32'hDEADBEEF}}, 1'b0, 1'b0);
        tick();
        chk("fl_loaded", o_data, {3{32'hDEADBEEF}});
        set(1'b1, {3{32'hCAFEF00D}}, 1'b0, 1'b1);
        tick();
        chk("fl_valid", BW'(o_valid), BW'(1'b0));
        chk("fl_data", o_data, '0);
        chk("fl_ready", BW'(o_ready), BW'(1'b1));
        set(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl_no_ghost", BW'(o_valid), BW'(1'b0));
        end

        // Asynchronous reset asserted mid-cycle with data held.
        set(1'b1, pack(32'h70), 1'b0, 1'b0);
        tick();
        set(1'b0, '0, 1'b0, 1'b0);
        #2;
        rstn = 1'b0;
        q.delete();
        last_data = '0;
        #1;
        chk("arst_valid", BW'(o_valid), BW'(1'b0));
        chk("arst_data", o_data, '0);
        chk("arst_ready", BW'(o_ready), BW'(1'b1));
        tick();
        rstn = 1'b1;
        tick();

        // Random valid/ready/flush traffic checked by the monitor.
        for (int i = 0; i < 3000; i++) begin
            set(1'($urandom_range(0, 1)),
                {$urandom(), $urandom(), $urandom()},
                1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 63) == 0));
            tick();
        end
        set(1'b0, '0, 1'b1, 1'b0);
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
